// File: rtl/lc3_fetch_pkg.sv
// Types and constants shared by the LC3 instruction-fetch stage.
package lc3_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DROP     = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] npc;
  } fetch_entry_t;

  localparam logic [15:0] LC3_RESET_PC = 16'h3000;

endpackage

// File: rtl/lc3_fetch_queue.sv
// Small synchronous ring FIFO of fetched {instr, npc} entries feeding decode.
// Push while full is never requested by the parent (slots are reserved at
// request time), so there is no overflow protection here.
module lc3_fetch_queue
  import lc3_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wr_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output fetch_entry_t                 head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // Ring storage, pointers and occupancy; flush drops everything at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC3 fetch stage: PC, imem request/ack FSM with slot reservation, and a
// small queue presenting {instr, npc} to decode. Branches flush everything.
module lc3_fetch_unit
  import lc3_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = LC3_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_fetch,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_dout,
  input  logic        decode_ready,
  output logic        enable_decode,
  output logic [15:0] Instr_dout,
  output logic [15:0] npc_out,
  output logic [15:0] pc
);

  localparam int           CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]  DEPTH_V = (CW + 1)'(DEPTH);

  fetch_state_e   state;
  fetch_entry_t   q_head;
  fetch_entry_t   q_wr;
  logic [CW-1:0]  q_count;
  logic           q_empty;
  logic           push;
  logic           pop;
  logic [15:0]    pc_inc;
  logic [CW:0]    count_ext;
  logic           slot_free_now;
  logic           slot_free_after;

  assign pc_inc    = pc + 16'd1;
  assign pop       = !q_empty && decode_ready;
  // A branch in the same cycle as the ack discards the returned word.
  assign push      = (state == WAIT_ACK) && imem_ack && !br_taken;
  assign q_wr      = '{instr: imem_dout, npc: pc_inc};
  assign count_ext = {1'b0, q_count};

  // In IDLE nothing is outstanding, so the queue count is the whole usage.
  assign slot_free_now   = count_ext < DEPTH_V;
  // After an ack the returned word takes its reserved slot; a new request
  // needs another free slot once this cycle's push and pop have settled.
  assign slot_free_after = (count_ext + 1'b1 - {{CW{1'b0}}, pop}) < DEPTH_V;

  assign enable_decode = !q_empty;
  assign Instr_dout    = q_head.instr;
  assign npc_out       = q_head.npc;

  lc3_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (br_taken),
    .wr_data (q_wr),
    .count   (q_count),
    .empty   (q_empty),
    .head    (q_head)
  );

  // Request FSM, PC and registered memory-side outputs; br_taken dominates.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_rd   <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (br_taken) begin
            // Queue is flushed this edge, so a slot is always free.
            pc <= taddr;
            if (enable_fetch) begin
              state     <= WAIT_ACK;
              imem_rd   <= 1'b1;
              imem_addr <= taddr;
            end
          end else if (enable_fetch && slot_free_now) begin
            state     <= WAIT_ACK;
            imem_rd   <= 1'b1;
            imem_addr <= pc;
          end
        end
        WAIT_ACK: begin
          if (br_taken) begin
            pc <= taddr;
            if (imem_ack) begin
              state   <= IDLE;
              imem_rd <= 1'b0;
            end else begin
              state <= DROP;
            end
          end else if (imem_ack) begin
            pc <= pc_inc;
            if (enable_fetch && slot_free_after) begin
              imem_addr <= pc_inc;
            end else begin
              state   <= IDLE;
              imem_rd <= 1'b0;
            end
          end
        end
        DROP: begin
          if (br_taken) pc <= taddr;
          // The stale ack always closes the handshake, even alongside a
          // new branch, so the FSM can never wait for an ack that won't come.
          if (imem_ack) begin
            state   <= IDLE;
            imem_rd <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          imem_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule
